sample_div: RTL and testbench

SAMPLE_DIV -- requirements
Module: sample_div

---
 rtl/sample_pkg.sv | 14 +
 rtl/sample_div_step.sv | 34 +++
 rtl/sample_div.sv | 111 +++++++++++
 tb/tb_sample_div.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// default operand widths.
package sample_pkg;

    localparam int NW_DEFAULT = 16;
    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/sample_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in one
// dividend bit, trial-subtract the divisor and keep the difference if it fits.
module sample_div_step
    import sample_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW:0]   rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW:0] shifted_s;
    logic [DW:0] diff_s;
    logic        ge_s;

    // A set top bit means the shifted value overflowed DW+1 bits, so it is
    // certainly larger than any divisor and the wrapped difference is exact.
    always_comb begin
        shifted_s = {rem_in[DW-1:0], bit_in};
        diff_s    = shifted_s - {1'b0, divisor};
        ge_s      = rem_in[DW] | (shifted_s >= {1'b0, divisor});
        if (ge_s) begin
            rem_out = diff_s;
        end else begin
            rem_out = shifted_s;
        end
    end

    assign q_bit = ge_s;

endmodule

// File: rtl/sample_div.sv
// Sequential unsigned restoring divider with valid/ready handshakes on both
// sides; one quotient bit per cycle, results held until consumed.
module sample_div
    import sample_pkg::*;
#(
    parameter int NW = NW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int            CW       = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NW - 1);

    div_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic [DW:0]   rem_r;
    logic [NW-1:0] dvd_r;
    logic [DW-1:0] dvs_r;

    logic [DW:0]   rem_next_s;
    logic          q_bit_s;
    logic [NW-1:0] quo_next_s;

    sample_div_step #(
        .DW (DW)
    ) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[NW-1]),
        .divisor (dvs_r),
        .rem_out (rem_next_s),
        .q_bit   (q_bit_s)
    );

    // The dividend register doubles as the quotient shift register: dividend
    // bits leave at the top while quotient bits enter at the bottom.
    assign quo_next_s = {dvd_r[NW-2:0], q_bit_s};

    // Control FSM, step counter, operand/partial-remainder and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dvd_r    <= dividend;
                        dvs_r    <= divisor;
                        rem_r    <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state_r     <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state_r     <= BUSY;
                            cnt_r       <= CNT_LOAD;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem_r <= rem_next_s;
                    dvd_r <= quo_next_s;
                    if (cnt_r == '0) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= quo_next_s;
                        remainder <= rem_next_s[DW-1:0];
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_div.sv
// Self-checking bench for sample_div: directed literal cases plus randomized
// traffic compared cycle by cycle against a timing/arithmetic reference model.
module tb_sample_div;
    import sample_pkg::*;

    localparam int NW       = NW_DEFAULT;
    localparam int DW       = DW_DEFAULT;
    localparam int N_RANDOM = 3000;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    sample_div #(
        .NW (NW),
        .DW (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result held.
    int            m_phase = 0;
    int            m_wait  = 0;
    int            m_ops   = 0;
    bit            m_armed = 1'b0;
    bit            m_zero  = 1'b0;
    logic [NW-1:0] m_q     = '0;
    logic [DW-1:0] m_r     = '0;
    logic          m_d     = 1'b0;

    // Compare DUT outputs against the model, then advance the model by the
    // handshake that the next rising edge will see.
    always @(negedge clk) begin
        logic [NW-1:0] tmp;
        if (m_armed) begin
            chk("in_ready", in_ready, (m_phase == 0));
            chk("out_valid", out_valid, (m_phase == 2));
            if (m_phase == 2 || m_zero) begin
                chk("model_quotient", quotient, m_q);
                chk("model_remainder", remainder, m_r);
                chk("model_div_by_zero", div_by_zero, m_d);
            end
        end
        m_zero = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            m_armed = 1'b1;
            m_zero  = 1'b1;
            m_q     = '0;
            m_r     = '0;
            m_d     = 1'b0;
        end else if (m_armed) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_ops++;
                    if (divisor == '0) begin
                        m_q     = '1;
                        m_r     = dividend[DW-1:0];
                        m_d     = 1'b1;
                        m_phase = 2;
                    end else begin
                        m_q     = dividend / {{(NW-DW){1'b0}}, divisor};
                        tmp     = dividend % {{(NW-DW){1'b0}}, divisor};
                        m_r     = tmp[DW-1:0];
                        m_d     = 1'b0;
                        m_phase = 1;
                        m_wait  = NW - 1;
                    end
                end
                1: if (m_wait == 0) m_phase = 2; else m_wait--;
                2: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // Directed operation with literal expectations, latency and backpressure.
    task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b, input int bp,
                          input int exp_lat, input logic [NW-1:0] eq,
                          input logic [DW-1:0] er, input logic ed);
        int w;
        int lat;
        @(posedge clk); #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("idle_before_op", in_ready, 1'b1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = NW'($urandom);
        divisor  = DW'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            dividend = NW'($urandom);
            divisor  = DW'($urandom);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ed);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_quotient", quotient, eq);
            chk("bp_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed_out_valid", out_valid, 1'b0);
        chk("consumed_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int base;
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_quotient", quotient, 16'h0000);
        chk("reset_remainder", remainder, 8'h00);
        chk("reset_div_by_zero", div_by_zero, 1'b0);

        run_op(16'd1000, 8'd7, 0, 17, 16'd142, 8'd6, 1'b0);
        run_op(16'hFFFF, 8'd1, 0, 17, 16'hFFFF, 8'd0, 1'b0);
        run_op(16'hFFFF, 8'd255, 0, 17, 16'd257, 8'd0, 1'b0);
        run_op(16'd5, 8'd10, 0, 17, 16'd0, 8'd5, 1'b0);
        run_op(16'd100, 8'd0, 0, 1, 16'hFFFF, 8'h64, 1'b1);
        run_op(16'd1000, 8'd7, 5, 17, 16'd142, 8'd6, 1'b0);

        // Abort a division with reset after eight steps.
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_quotient", quotient, 16'h0000);
        chk("abort_remainder", remainder, 8'h00);
        chk("abort_div_by_zero", div_by_zero, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("abort_no_out_valid", out_valid, 1'b0);
        end
        run_op(16'd200, 8'd3, 0, 17, 16'd66, 8'd2, 1'b0);

        // Randomized traffic, including operand churn while busy.
        base = m_ops;
        cyc  = 0;
        while ((m_ops - base) < N_RANDOM && cyc < 90000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       dividend = NW'($urandom_range(0, 255));
                1:       dividend = '1;
                default: dividend = NW'($urandom);
            endcase
            case ($urandom_range(0, 15))
                0:       divisor = '0;
                1:       divisor = '1;
                2:       divisor = DW'(1);
                default: divisor = DW'($urandom);
            endcase
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (m_phase != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_ops_done", ((m_ops - base) >= N_RANDOM), 1'b1);
        chk("drained_idle", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
